// File: rtl/histogram_builder_pkg.sv
// Shared histogram definitions: bin count, default word/frame sizes and FSM encodings.
// The cumulative-histogram stage imports this package as well.
package histogram_builder_pkg;
  localparam int HIST_BINS    = 256;
  localparam int HIST_WORD    = 20;
  localparam int FRAME_PIXELS = 800*480;
  localparam int PIPE_STAGES  = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ACCUM = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/histogram_builder_rmw_pipe.sv
// Read-modify-write pipeline for one pixel per cycle into the histogram RAM,
// with forwarding from the two most recent writes and a saturating increment.
module hist_rmw_pipe
  import histogram_builder_pkg::*;
#(
  parameter int word_size = HIST_WORD
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iFlush,
  input  logic                 iAcc,
  input  logic [7:0]           iPixel,
  input  logic [word_size-1:0] iQHist,
  output logic [7:0]           oAddrRd,
  output logic                 oWE,
  output logic [7:0]           oAddrWr,
  output logic [word_size-1:0] oDataWr
);
  // [1] read issued, [2] read data back, [3] write now (W1), [4] previous write (W2)
  logic [PIPE_STAGES:1]  vld_pipe;
  logic [7:0]            s1_bin, s2_bin, w2_bin;
  logic [word_size-1:0]  w2_data, base, nxt;

  assign oAddrRd = s1_bin;
  assign oWE     = vld_pipe[3];

  // W2 is needed because the RAM is read-first: the read overlapping W2's write saw stale data
  always_comb begin
    base = iQHist;
    if (vld_pipe[3] && oAddrWr == s2_bin)      base = oDataWr;
    else if (vld_pipe[4] && w2_bin == s2_bin)  base = w2_data;
    nxt = (&base) ? base : base + word_size'(1);
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      vld_pipe <= '0;
      s1_bin   <= '0;
      s2_bin   <= '0;
      oAddrWr  <= '0;
      oDataWr  <= '0;
      w2_bin   <= '0;
      w2_data  <= '0;
    end else if (iFlush) begin
      vld_pipe <= '0;
      s1_bin   <= '0;
      s2_bin   <= '0;
      oAddrWr  <= '0;
      oDataWr  <= '0;
      w2_bin   <= '0;
      w2_data  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[PIPE_STAGES-1:1], iAcc};
      s1_bin   <= iAcc ? iPixel : 8'd0;
      s2_bin   <= s1_bin;
      oAddrWr  <= vld_pipe[2] ? s2_bin : 8'd0;
      oDataWr  <= vld_pipe[2] ? nxt : '0;
      w2_bin   <= oAddrWr;
      w2_data  <= oDataWr;
    end
  end
endmodule

// File: rtl/histogram_builder.sv
// Histogram RAM writer: clears all bins, accumulates one frame of pixels, then
// holds done until acknowledged.
module histogram_builder
  import histogram_builder_pkg::*;
#(
  parameter int word_size   = HIST_WORD,
  parameter int pixel_count = FRAME_PIXELS,
  parameter int cnt_bits    = 19
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iStart,
  input  logic [7:0]           iPixel,
  input  logic                 iValid,
  output logic                 oReady,
  output logic [7:0]           oAddrRdHist,
  input  logic [word_size-1:0] iQHist,
  output logic [7:0]           oAddrWrHist,
  output logic [word_size-1:0] oDataWrHist,
  output logic                 oWE,
  output logic                 oBusy,
  output logic                 oDone,
  input  logic                 iDoneAck
);
  state_t                state;
  logic [7:0]            clr_addr;
  logic [cnt_bits-1:0]   cnt;
  logic [1:0]            drain;
  logic                  accept, clr_we, p_we;
  logic [7:0]            p_addr;
  logic [word_size-1:0]  p_data;

  assign oReady = (state == ST_ACCUM) && (cnt < cnt_bits'(pixel_count));
  assign accept = iValid & oReady;
  assign oBusy  = (state == ST_CLEAR) || (state == ST_ACCUM) || (state == ST_DRAIN);
  assign oDone  = (state == ST_DONE);
  assign clr_we = (state == ST_CLEAR);

  // Clear writes and pipeline writes never overlap: iStart flushes the pipe before CLEAR.
  assign oWE         = clr_we | p_we;
  assign oAddrWrHist = clr_we ? clr_addr : p_addr;
  assign oDataWrHist = clr_we ? '0 : p_data;

  hist_rmw_pipe #(.word_size(word_size)) u_pipe (
    .iClk    (iClk),
    .iRst    (iRst),
    .iFlush  (iStart),
    .iAcc    (accept),
    .iPixel  (iPixel),
    .iQHist  (iQHist),
    .oAddrRd (oAddrRdHist),
    .oWE     (p_we),
    .oAddrWr (p_addr),
    .oDataWr (p_data)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state    <= ST_IDLE;
      clr_addr <= '0;
      cnt      <= '0;
      drain    <= '0;
    end else if (iStart) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
      cnt      <= '0;
      drain    <= '0;
    end else begin
      case (state)
        ST_IDLE: ;
        ST_CLEAR: begin
          clr_addr <= clr_addr + 8'd1;
          if (clr_addr == 8'hFF) state <= ST_ACCUM;
        end
        ST_ACCUM: if (accept) begin
          cnt <= cnt + cnt_bits'(1);
          if (cnt == cnt_bits'(pixel_count - 1)) begin
            state <= ST_DRAIN;
            drain <= '0;
          end
        end
        // three cycles lets the last pixel's write issue before done rises
        ST_DRAIN: begin
          drain <= drain + 2'd1;
          if (drain == 2'd2) state <= ST_DONE;
        end
        ST_DONE: if (iDoneAck) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_histogram_builder.sv
// Directed bench for histogram_builder with read-first RAM models and golden bin counts.
module tb_histogram_builder;
  logic        clk = 0, rst = 1, fill = 0;
  logic        st = 0, vl = 0, ack = 0;
  logic [7:0]  px = 0;
  logic        rdy, we, busy, done;
  logic [7:0]  ra, wa;
  logic [19:0] wd, q;
  logic [19:0] ram [256];
  int          gold [256];

  logic        s_st = 0, s_vl = 0, s_ack = 0;
  logic [7:0]  s_px = 0;
  logic        s_rdy, s_we, s_busy, s_done;
  logic [7:0]  s_ra, s_wa;
  logic [2:0]  s_wd, s_q;
  logic [2:0]  ram_s [256];

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  histogram_builder #(.word_size(20), .pixel_count(16), .cnt_bits(19)) dut (
    .iClk(clk), .iRst(rst), .iStart(st), .iPixel(px), .iValid(vl), .oReady(rdy),
    .oAddrRdHist(ra), .iQHist(q), .oAddrWrHist(wa), .oDataWrHist(wd), .oWE(we),
    .oBusy(busy), .oDone(done), .iDoneAck(ack));

  histogram_builder #(.word_size(3), .pixel_count(10), .cnt_bits(19)) dsat (
    .iClk(clk), .iRst(rst), .iStart(s_st), .iPixel(s_px), .iValid(s_vl), .oReady(s_rdy),
    .oAddrRdHist(s_ra), .iQHist(s_q), .oAddrWrHist(s_wa), .oDataWrHist(s_wd), .oWE(s_we),
    .oBusy(s_busy), .oDone(s_done), .iDoneAck(s_ack));

  // read-first RAM models
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 256; i++) ram[i] <= 20'hAAAAA;
    end else begin
      q <= ram[ra];
      if (we) ram[wa] <= wd;
    end
  end

  always @(posedge clk) begin
    s_q <= ram_s[s_ra];
    if (s_we) ram_s[s_wa] <= s_wd;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic int hist_errs();
    int e = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== 20'(gold[i])) e++;
    return e;
  endfunction

  task automatic start_clear();
    for (int i = 0; i < 256; i++) gold[i] = 0;
    st = 1; tick(); st = 0;
    repeat (256) tick();
  endtask

  task automatic send(input logic [7:0] p);
    px = p; vl = 1;
    if (rdy) gold[p]++;
    tick();
    vl = 0; px = 0;
  endtask

  task automatic test_reset();
    int e;
    rst = 1; #3;
    total++; if ({we, ra, wa, wd, rdy, busy, done} !== '0) begin bad++;
      $display("FAIL reset_outputs: got %0h want 0", {we, ra, wa, wd, rdy, busy, done}); end
    tick(); tick(); rst = 0; tick();
    start_clear();
    send(8'd3); send(8'd3); send(8'd4);
    rst = 1; #1;
    total++; if ({we, ra, wa, wd, rdy, busy, done} !== '0) begin bad++;
      $display("FAIL reset_mid_accum: got %0h want 0", {we, ra, wa, wd, rdy, busy, done}); end
    tick(); rst = 0; tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy: got %0b want 0", busy); end
    start_clear();
    for (int i = 0; i < 16; i++) send(8'(i % 5));
    repeat (3) tick();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL reset_frame_done: got %0b want 1", done); end
    total++; if (ram[0] !== 20'd4) begin bad++; $display("FAIL reset_bin0: got %0d want 4", ram[0]); end
    e = hist_errs();
    total++; if (e !== 0) begin bad++; $display("FAIL reset_hist: got %0d bad bins want 0", e); end
    ack = 1; tick(); ack = 0;
  endtask

  task automatic test_clear();
    int e = 0;
    fill = 1; tick(); fill = 0;
    for (int i = 0; i < 256; i++) gold[i] = 0;
    st = 1; tick(); st = 0;
    for (int k = 1; k <= 256; k++) begin
      total++; if (we !== 1'b1 || wa !== 8'(k - 1) || wd !== 20'd0 || rdy !== 1'b0) begin bad++;
        $display("FAIL clear_write cyc %0d: got we=%0b addr=%0d data=%0h rdy=%0b want we=1 addr=%0d data=0 rdy=0",
                 k, we, wa, wd, rdy, k - 1); end
      tick();
    end
    total++; if (rdy !== 1'b1 || we !== 1'b0 || busy !== 1'b1) begin bad++;
      $display("FAIL clear_to_accum: got rdy=%0b we=%0b busy=%0b want 1 0 1", rdy, we, busy); end
    e = hist_errs();
    total++; if (e !== 0) begin bad++; $display("FAIL clear_ram_zero: got %0d nonzero bins want 0", e); end
  endtask

  task automatic test_back_to_back();
    int e;
    start_clear();
    for (int i = 0; i < 16; i++) send(8'd7);
    total++; if (rdy !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin bad++;
      $display("FAIL b2b_t1: got rdy=%0b busy=%0b done=%0b want 0 1 0", rdy, busy, done); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_t2_done: got %0b want 0", done); end
    tick();
    total++; if (we !== 1'b1 || wa !== 8'd7 || wd !== 20'd16) begin bad++;
      $display("FAIL b2b_last_write: got we=%0b addr=%0d data=%0d want 1 7 16", we, wa, wd); end
    tick();
    total++; if (done !== 1'b1 || busy !== 1'b0 || we !== 1'b0) begin bad++;
      $display("FAIL b2b_done: got done=%0b busy=%0b we=%0b want 1 0 0", done, busy, we); end
    total++; if (ram[7] !== 20'd16) begin bad++; $display("FAIL b2b_bin7: got %0d want 16", ram[7]); end
    e = hist_errs();
    total++; if (e !== 0) begin bad++; $display("FAIL b2b_hist: got %0d bad bins want 0", e); end
  endtask

  task automatic test_handshake();
    int miss = 0;
    for (int i = 0; i < 20; i++) begin
      if (done !== 1'b1) miss++;
      tick();
    end
    total++; if (miss !== 0) begin bad++; $display("FAIL hs_hold: got %0d low cycles want 0", miss); end
    ack = 1; #1;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL hs_ack_cycle: got %0b want 1", done); end
    tick(); ack = 0;
    total++; if (done !== 1'b0 || busy !== 1'b0 || we !== 1'b0) begin bad++;
      $display("FAIL hs_idle: got done=%0b busy=%0b we=%0b want 0 0 0", done, busy, we); end
    ack = 1; tick(); ack = 0;
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++;
      $display("FAIL hs_ack_ignored: got done=%0b busy=%0b want 0 0", done, busy); end
  endtask

  task automatic test_gap2();
    int e;
    start_clear();
    for (int i = 0; i < 12; i++) send((i % 2) ? 8'd9 : 8'd7);
    send(8'd3);
    repeat ($urandom_range(1, 2)) tick();
    send(8'd5);
    repeat ($urandom_range(1, 2)) tick();
    send(8'd3);
    repeat ($urandom_range(1, 2)) tick();
    send(8'd3);
    repeat (3) tick();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL gap2_done: got %0b want 1", done); end
    total++; if (ram[7] !== 20'd6 || ram[9] !== 20'd6) begin bad++;
      $display("FAIL gap2_bins79: got %0d %0d want 6 6", ram[7], ram[9]); end
    total++; if (ram[3] !== 20'd3 || ram[5] !== 20'd1) begin bad++;
      $display("FAIL gap2_bins35: got %0d %0d want 3 1", ram[3], ram[5]); end
    e = hist_errs();
    total++; if (e !== 0) begin bad++; $display("FAIL gap2_hist: got %0d bad bins want 0", e); end
    ack = 1; tick(); ack = 0;
  endtask

  task automatic test_restart();
    int e, stale = 0;
    start_clear();
    for (int i = 0; i < 5; i++) send(8'd50);
    st = 1; tick(); st = 0;
    total++; if (we !== 1'b1 || wa !== 8'd0 || wd !== 20'd0 || rdy !== 1'b0 || busy !== 1'b1) begin bad++;
      $display("FAIL restart_clear0: got we=%0b addr=%0d data=%0h rdy=%0b busy=%0b want 1 0 0 0 1",
               we, wa, wd, rdy, busy); end
    for (int k = 2; k <= 256; k++) begin
      tick();
      if (we !== 1'b1 || wd !== 20'd0 || wa !== 8'(k - 1)) stale++;
    end
    tick();
    total++; if (stale !== 0) begin bad++; $display("FAIL restart_stale: got %0d bad clear cycles want 0", stale); end
    total++; if (rdy !== 1'b1 || ram[50] !== 20'd0) begin bad++;
      $display("FAIL restart_accum: got rdy=%0b bin50=%0d want 1 0", rdy, ram[50]); end
    for (int i = 0; i < 256; i++) gold[i] = 0;
    for (int i = 0; i < 16; i++) send(8'(i * 16));
    repeat (3) tick();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL restart_done: got %0b want 1", done); end
    total++; if (ram[16] !== 20'd1 || ram[50] !== 20'd0) begin bad++;
      $display("FAIL restart_bins: got bin16=%0d bin50=%0d want 1 0", ram[16], ram[50]); end
    e = hist_errs();
    total++; if (e !== 0) begin bad++; $display("FAIL restart_hist: got %0d bad bins want 0", e); end
    st = 1; ack = 1; tick(); st = 0; ack = 0;
    total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++;
      $display("FAIL start_beats_ack: got busy=%0b done=%0b want 1 0", busy, done); end
  endtask

  task automatic test_saturation();
    int nz = 0, notrdy = 0;
    s_st = 1; tick(); s_st = 0;
    repeat (256) tick();
    for (int i = 0; i < 10; i++) begin
      if (s_rdy !== 1'b1) notrdy++;
      s_px = 8'd200; s_vl = 1; tick(); s_vl = 0;
    end
    total++; if (notrdy !== 0) begin bad++; $display("FAIL sat_ready: got %0d stalls want 0", notrdy); end
    tick(); tick();
    total++; if (s_we !== 1'b1 || s_wa !== 8'd200 || s_wd !== 3'd7) begin bad++;
      $display("FAIL sat_last_write: got we=%0b addr=%0d data=%0d want 1 200 7", s_we, s_wa, s_wd); end
    tick();
    total++; if (s_done !== 1'b1 || s_busy !== 1'b0) begin bad++;
      $display("FAIL sat_done: got done=%0b busy=%0b want 1 0", s_done, s_busy); end
    total++; if (ram_s[200] !== 3'd7) begin bad++; $display("FAIL sat_bin200: got %0d want 7", ram_s[200]); end
    for (int i = 0; i < 256; i++) if (i != 200 && ram_s[i] !== 3'd0) nz++;
    total++; if (nz !== 0) begin bad++; $display("FAIL sat_other_bins: got %0d nonzero want 0", nz); end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_back_to_back();
    test_handshake();
    test_gap2();
    test_restart();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
